// File: rtl/instruction_decoder.sv
// Decode stage: pops variable-length instructions from a show-ahead command FIFO,
// assembles fixed-format entries and queues them in a 2-deep buffer for the engines.
module instruction_decoder #(
    parameter int COORD_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               decode_en,
    input  logic               fifo_empty,
    input  logic [DATA_W-1:0]  fifo_rdata,
    output logic               fifo_rd,
    input  logic               draw_take,
    output logic               cmd_valid,
    output logic [2:0]         cmd_op,
    output logic [23:0]        cmd_color,
    output logic [COORD_W-1:0] cmd_x0,
    output logic [COORD_W-1:0] cmd_y0,
    output logic [COORD_W-1:0] cmd_x1,
    output logic [COORD_W-1:0] cmd_y1,
    output logic [COORD_W-1:0] cmd_x2,
    output logic [COORD_W-1:0] cmd_y2,
    output logic               decode_fin,
    output logic               decode_full,
    output logic               inst_type,
    output logic               decode_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARGS  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]         op;
        logic [23:0]        color;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
    } entry_t;

    function automatic logic [COORD_W-1:0] trunc_coord(input logic [15:0] field);
        return COORD_W'(field);
    endfunction

    function automatic logic [1:0] arg_count(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 2'd2;
            3'd3:       return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    state_t             state, state_n;
    logic [1:0]         arg_idx;
    logic [1:0]         count;
    entry_t             buf0, buf1, new_ent;

    logic [2:0]         op_p0;
    logic [23:0]        color_p0;
    logic [COORD_W-1:0] x0_p0, y0_p0, x1_p0, y1_p0, x2_p0, y2_p0;

    logic [3:0]         hdr_op;
    logic               hdr_legal;
    logic               hdr_alpha;
    logic               pop_ok;
    logic               pop_hdr;
    logic               pop_arg;
    logic               last_arg;
    logic               wr;
    logic               take;

    assign hdr_op    = fifo_rdata[31:28];
    assign hdr_legal = (hdr_op >= 4'd1) && (hdr_op <= 4'd4);
    assign hdr_alpha = (hdr_op == 4'd4);
    assign pop_ok    = decode_en && !fifo_empty && !rst;
    assign last_arg  = (arg_idx == (arg_count(op_p0) - 2'd1));

    always_comb begin
        state_n = state;
        fifo_rd = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop_ok && (count < 2'd2)) begin
                    fifo_rd = 1'b1;
                    if (hdr_legal) begin
                        state_n = hdr_alpha ? S_WRITE : S_ARGS;
                    end
                end
            end
            S_ARGS: begin
                if (pop_ok) begin
                    fifo_rd = 1'b1;
                    if (last_arg) begin
                        state_n = S_WRITE;
                    end
                end
            end
            S_WRITE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign pop_hdr = fifo_rd && (state == S_IDLE);
    assign pop_arg = fifo_rd && (state == S_ARGS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            arg_idx    <= 2'd0;
            decode_err <= 1'b0;
        end else begin
            state      <= state_n;
            decode_err <= pop_hdr && !hdr_legal;
            if (pop_hdr) begin
                arg_idx <= 2'd0;
            end else if (pop_arg) begin
                arg_idx <= arg_idx + 2'd1;
            end
        end
    end

    // Stage p0: instruction assembly (header fields, then one coordinate pair per argument)
    always_ff @(posedge clk) begin
        if (pop_hdr && hdr_legal) begin
            op_p0    <= hdr_op[2:0];
            color_p0 <= hdr_alpha ? {16'h0000, fifo_rdata[7:0]} : fifo_rdata[23:0];
            x0_p0    <= '0;
            y0_p0    <= '0;
            x1_p0    <= '0;
            y1_p0    <= '0;
            x2_p0    <= '0;
            y2_p0    <= '0;
        end else if (pop_arg) begin
            case (arg_idx)
                2'd0: begin
                    x0_p0 <= trunc_coord(fifo_rdata[31:16]);
                    y0_p0 <= trunc_coord(fifo_rdata[15:0]);
                end
                2'd1: begin
                    x1_p0 <= trunc_coord(fifo_rdata[31:16]);
                    y1_p0 <= trunc_coord(fifo_rdata[15:0]);
                end
                default: begin
                    x2_p0 <= trunc_coord(fifo_rdata[31:16]);
                    y2_p0 <= trunc_coord(fifo_rdata[15:0]);
                end
            endcase
        end
    end

    always_comb begin
        new_ent       = '0;
        new_ent.op    = op_p0;
        new_ent.color = color_p0;
        new_ent.x0    = x0_p0;
        new_ent.y0    = y0_p0;
        new_ent.x1    = x1_p0;
        new_ent.y1    = y1_p0;
        new_ent.x2    = x2_p0;
        new_ent.y2    = y2_p0;
    end

    assign wr   = (state == S_WRITE);
    assign take = draw_take && (count != 2'd0);

    // Output buffer stage: buf0 is the head; vacated slots are zeroed so an empty buffer reads 0.
    // A write only ever happens with count<=1, so write+take implies count==1 and buf1 is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            buf0  <= '0;
            buf1  <= '0;
        end else if (wr && take) begin
            buf0 <= new_ent;
        end else if (wr) begin
            if (count == 2'd0) begin
                buf0 <= new_ent;
            end else begin
                buf1 <= new_ent;
            end
            count <= count + 2'd1;
        end else if (take) begin
            buf0  <= buf1;
            buf1  <= '0;
            count <= count - 2'd1;
        end
    end

    assign cmd_valid   = (count != 2'd0);
    assign cmd_op      = buf0.op;
    assign cmd_color   = buf0.color;
    assign cmd_x0      = buf0.x0;
    assign cmd_y0      = buf0.y0;
    assign cmd_x1      = buf0.x1;
    assign cmd_y1      = buf0.y1;
    assign cmd_x2      = buf0.x2;
    assign cmd_y2      = buf0.y2;
    assign decode_fin  = wr;
    assign decode_full = (count == 2'd2);
    assign inst_type   = cmd_valid && (buf0.op == 3'd4);

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed scenarios plus randomized instruction
// streams scored against a transaction-level model of the decoded entries.
module tb_instruction_decoder;
    localparam int CW = 10;
    localparam int EW = 27 + 6 * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          decode_en;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic          fifo_rd;
    logic          draw_take;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [23:0]   cmd_color;
    logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2;
    logic          decode_fin;
    logic          decode_full;
    logic          inst_type;
    logic          decode_err;

    always #5 clk = ~clk;

    instruction_decoder #(.COORD_W(CW), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .decode_en(decode_en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .draw_take(draw_take),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_color(cmd_color),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_x2(cmd_x2), .cmd_y2(cmd_y2), .decode_fin(decode_fin),
        .decode_full(decode_full), .inst_type(inst_type), .decode_err(decode_err)
    );

    logic [31:0]   fifo_q[$];
    logic [31:0]   pend_q[$];
    logic [EW-1:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt = 0, fin_cnt = 0, err_cnt = 0;
    int n_legal = 0, n_illegal = 0;
    bit chk_inv = 1'b0;
    bit feed_en = 1'b0;

    logic          s_rd, s_fin, s_err, s_valid, s_full, s_inst;
    logic [EW-1:0] s_ent;
    logic [CW-1:0] s_x0, s_y0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference entry: coordinates reduced modulo 2**CW, unused ones zero.
    function automatic logic [EW-1:0] mk(input int op, input logic [23:0] col,
                                         input int x0, input int y0, input int x1,
                                         input int y1, input int x2, input int y2);
        int m;
        m = 1 << CW;
        return {3'(op), col, CW'(x0 % m), CW'(y0 % m), CW'(x1 % m),
                CW'(y1 % m), CW'(x2 % m), CW'(y2 % m)};
    endfunction

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic push_instr(input int op, input bit to_pend);
        int          nargs;
        int          xs[3];
        int          ys[3];
        logic [23:0] col;
        logic [3:0]  junk;
        logic [31:0] w;
        logic [23:0] ecol;
        col   = 24'($urandom);
        junk  = 4'($urandom_range(0, 15));
        nargs = (op == 1 || op == 2) ? 2 : (op == 3) ? 3 : 0;
        for (int i = 0; i < 3; i++) begin
            xs[i] = 0;
            ys[i] = 0;
        end
        w = {4'(op), junk, col};
        if (to_pend) pend_q.push_back(w); else push_word(w);
        for (int i = 0; i < nargs; i++) begin
            xs[i] = $urandom_range(0, 65535);
            ys[i] = $urandom_range(0, 65535);
            w = {16'(xs[i]), 16'(ys[i])};
            if (to_pend) pend_q.push_back(w); else push_word(w);
        end
        if (op >= 1 && op <= 4) begin
            ecol = (op == 4) ? {16'h0, col[7:0]} : col;
            exp_q.push_back(mk(op, ecol, xs[0], ys[0], xs[1], ys[1], xs[2], ys[2]));
            n_legal++;
        end else begin
            n_illegal++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_rd    = fifo_rd;
        s_fin   = decode_fin;
        s_err   = decode_err;
        s_valid = cmd_valid;
        s_full  = decode_full;
        s_inst  = inst_type;
        s_x0    = cmd_x0;
        s_y0    = cmd_y0;
        s_ent   = {cmd_op, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2};
        if (s_rd) pop_cnt++;
        if (s_fin) fin_cnt++;
        if (s_err) err_cnt++;
        if (draw_take && s_valid) begin
            if (exp_q.size() == 0) check("sb_extra_entry", s_valid, 0);
            else check("sb_entry", s_ent, exp_q.pop_front());
        end
        if (chk_inv) check("inst_type", s_inst, s_valid && (s_ent[EW-1 -: 3] == 3'd4));
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (feed_en && pend_q.size() > 0 && $urandom_range(0, 9) < 6)
            fifo_q.push_back(pend_q.pop_front());
        refresh();
    endtask

    task automatic drain();
        draw_take = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!s_valid) break;
        end
        draw_take = 1'b0;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_fin(input string tag, input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (s_fin) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rd_v;
        logic [4:0] fin_v;
        int         p0, f0, e0, il0, lg0;
        bit         done;

        rst = 1'b1; decode_en = 1'b0; draw_take = 1'b0;
        refresh();
        tick(); tick();

        // T1: LINE decode timing and fields, reset state in cycle 1
        push_word(32'h1000FF00); push_word(32'h00050006); push_word(32'h00100020);
        exp_q.push_back(mk(1, 24'h00FF00, 5, 6, 16, 32, 0, 0));
        decode_en = 1'b1; rst = 1'b0;
        rd_v = '0; fin_v = '0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) rd_v[c-1] = s_rd;
            fin_v[c-1] = s_fin;
            if (c == 1) begin
                check("rst_valid", s_valid, 0);
                check("rst_full", s_full, 0);
                check("rst_fin", s_fin, 0);
                check("rst_err", s_err, 0);
                check("rst_inst", s_inst, 0);
                check("rst_cmd", s_ent, 0);
            end
        end
        check("t1_rd_cycles", rd_v, 4'b0111);
        check("t1_fin_cycles", fin_v, 5'b01000);
        check("t1_valid", s_valid, 1);
        check("t1_entry", s_ent, mk(1, 24'h00FF00, 5, 6, 16, 32, 0, 0));
        drain();

        // T2: ALPHA
        push_word(32'h40000080);
        exp_q.push_back(mk(4, 24'h000080, 0, 0, 0, 0, 0, 0));
        tick(); check("t2_pop", s_rd, 1);
        tick(); check("t2_fin", s_fin, 1);
        tick();
        check("t2_entry", s_ent, mk(4, 24'h000080, 0, 0, 0, 0, 0, 0));
        check("t2_inst_type", s_inst, 1);
        drain();

        // T3: buffer fills, third header held back until a take
        p0 = pop_cnt; f0 = fin_cnt;
        push_instr(2, 0); push_instr(2, 0); push_instr(2, 0);
        repeat (20) tick();
        check("t3_full", s_full, 1);
        check("t3_pops", pop_cnt - p0, 6);
        check("t3_fins", fin_cnt - f0, 2);
        check("t3_fifo_left", fifo_q.size(), 3);
        draw_take = 1'b1; tick(); draw_take = 1'b0;
        wait_fin("t3_third_fin", 12);
        tick();
        check("t3_full_again", s_full, 1);
        drain();

        // T4: TRI with decode_en dropped after second argument
        p0 = pop_cnt; f0 = fin_cnt; done = 1'b0;
        push_instr(3, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pop_cnt - p0 == 3) begin
                done = 1'b1;
                break;
            end
        end
        check("t4_first_pops", done, 1);
        decode_en = 1'b0;
        p0 = pop_cnt;
        repeat (5) tick();
        check("t4_pops_while_off", pop_cnt - p0, 0);
        decode_en = 1'b1;
        wait_fin("t4_fin_seen", 10);
        repeat (3) tick();
        check("t4_fin_count", fin_cnt - f0, 1);
        drain();

        // T5: illegal opcode dropped, next instruction decodes
        e0 = err_cnt; f0 = fin_cnt;
        push_word(32'h9ABCDEF0);
        push_instr(1, 0);
        wait_fin("t5_fin_seen", 10);
        repeat (2) tick();
        check("t5_err_pulses", err_cnt - e0, 1);
        check("t5_fin_count", fin_cnt - f0, 1);
        drain();

        // T6: reset while in ARGS with one buffered entry
        push_instr(1, 0);
        wait_fin("t6_fin_seen", 10);
        tick();
        push_word(32'h20001234); push_word(32'h00010002);
        repeat (4) tick();
        check("t6_pre_valid", s_valid, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        fifo_q.delete(); exp_q.delete(); refresh();
        tick();
        check("t6_valid", s_valid, 0);
        check("t6_full", s_full, 0);
        check("t6_cmd", s_ent, 0);
        push_instr(4, 0);
        tick(); check("t6_idle_pop", s_rd, 1);
        tick(); check("t6_idle_fin", s_fin, 1);
        tick();
        drain();

        // T7: coordinate truncation
        push_word(32'h10000001); push_word(32'hFFFF8001); push_word(32'h00000000);
        exp_q.push_back(mk(1, 24'h000001, 'hFFFF, 'h8001, 0, 0, 0, 0));
        wait_fin("t7_fin_seen", 10);
        tick();
        check("t7_x0", s_x0, 10'h3FF);
        check("t7_y0", s_y0, 10'h001);
        drain();

        // Random phase: mixed legal/illegal streams, FIFO gaps, stalls and takes
        e0 = err_cnt; f0 = fin_cnt; il0 = n_illegal; lg0 = n_legal;
        for (int k = 0; k < 60; k++) begin
            int r, op;
            r = $urandom_range(0, 9);
            if (r < 8) op = 1 + (r % 4);
            else begin
                op = $urandom_range(5, 16);
                if (op == 16) op = 0;
            end
            push_instr(op, 1);
        end
        chk_inv = 1'b1; feed_en = 1'b1; done = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            decode_en = ($urandom_range(0, 9) < 8);
            draw_take = 1'($urandom_range(0, 1));
            tick();
            if (pend_q.size() == 0 && fifo_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("rnd_stream_done", done, 1);
        decode_en = 1'b1; draw_take = 1'b0;
        repeat (6) tick();
        drain();
        check("rnd_err_count", err_cnt - e0, n_illegal - il0);
        check("rnd_fin_count", fin_cnt - f0, n_legal - lg0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
